// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out feeder for a serial sequence detector. Words are
//   accepted over a valid/ready handshake and presented one bit per clock on
//   ser_out. A new word can be accepted on the edge that ends the last bit of
//   the current frame, so consecutive words stream with no idle gap.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: load_data[WIDTH-1] goes out first, 0: load_data[0] first
//   IDLE_BIT   level held on ser_out while no frame bit is presented
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   load_valid  upstream offers load_data
//   load_data   word to serialize, sampled only on an accepted load
//   load_ready  a word can be accepted this cycle (combinational)
//   ser_out     serial bit (registered)
//   ser_valid   ser_out carries a frame bit (registered)
//   busy        frame in progress, identical to ser_valid
//   frame_done  high during the last bit of every frame
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sr, sr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               bit_q, bit_nxt;
  logic               last;
  logic               accept;

  // The bit at the output end of a word, as selected by the bit order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Handshake and status decode, all from registered state.
  assign last       = (state == SHIFT) && (cnt == LAST);
  assign frame_done = last;
  assign load_ready = (state == IDLE) || last;
  assign accept     = load_valid && load_ready;
  assign ser_valid  = (state == SHIFT);
  assign busy       = ser_valid;
  assign ser_out    = bit_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    bit_nxt   = bit_q;

    if (state == IDLE) begin
      if (accept) begin
        state_nxt = SHIFT;
        sr_nxt    = load_data;
        cnt_nxt   = '0;
        bit_nxt   = first_bit(load_data);
      end
    end else if (!last) begin
      // Move the next bit to the output end; ser_out takes it from there.
      cnt_nxt = cnt + CNT_W'(1);
      sr_nxt  = MSB_FIRST ? (sr << 1) : (sr >> 1);
      bit_nxt = first_bit(sr_nxt);
    end else if (accept) begin
      // Reload on the last-bit edge keeps the stream gapless.
      sr_nxt  = load_data;
      cnt_nxt = '0;
      bit_nxt = first_bit(load_data);
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      bit_nxt   = IDLE_BIT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      bit_q <= IDLE_BIT;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      bit_q <= bit_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Two instances: the default 8-bit MSB-first one with idle level 0, and a
//   4-bit LSB-first one with idle level 1. Each has a reference model that is
//   a queue of bits still to be presented: an accepted word appends its bits
//   in transmit order, one bit leaves the queue per clock, and every output is
//   derived from the queue (front bit, empty, one left).
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk;
  logic       rst;

  logic       v8, rdy8, so8, sv8, busy8, fd8;
  logic [7:0] d8;
  logic       v4, rdy4, so4, sv4, busy4, fd4;
  logic [3:0] d4;

  int passed = 0;
  int total  = 0;

  bit q8[$];
  bit q4[$];
  bit cap8[$];
  bit cap4[$];
  int fdc8 = 0;
  int fdc4 = 0;

  piso_serializer dut8 (
    .clk        (clk),
    .rst        (rst),
    .load_valid (v8),
    .load_data  (d8),
    .load_ready (rdy8),
    .ser_out    (so8),
    .ser_valid  (sv8),
    .busy       (busy8),
    .frame_done (fd8)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .load_valid (v4),
    .load_data  (d4),
    .load_ready (rdy4),
    .ser_out    (so4),
    .ser_valid  (sv4),
    .busy       (busy4),
    .frame_done (fd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Bits collected in order; first bit ends up most significant.
  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  // Index of the bit on which a 111 detector would first fire, -1 if never.
  function automatic int first_111(input bit q[$]);
    int run = 0;
    foreach (q[i]) begin
      run = q[i] ? run + 1 : 0;
      if (run == 3) return i;
    end
    return -1;
  endfunction

  task automatic compare_all();
    check("ser_out8",    {31'd0, so8},   {31'd0, (q8.size() > 0) ? q8[0] : 1'b0});
    check("ser_valid8",  {31'd0, sv8},   {31'd0, q8.size() > 0});
    check("busy8",       {31'd0, busy8}, {31'd0, q8.size() > 0});
    check("frame_done8", {31'd0, fd8},   {31'd0, q8.size() == 1});
    check("load_ready8", {31'd0, rdy8},  {31'd0, q8.size() <= 1});
    check("ser_out4",    {31'd0, so4},   {31'd0, (q4.size() > 0) ? q4[0] : 1'b1});
    check("ser_valid4",  {31'd0, sv4},   {31'd0, q4.size() > 0});
    check("busy4",       {31'd0, busy4}, {31'd0, q4.size() > 0});
    check("frame_done4", {31'd0, fd4},   {31'd0, q4.size() == 1});
    check("load_ready4", {31'd0, rdy4},  {31'd0, q4.size() <= 1});
  endtask

  // One clock: inputs are already driven; advance models, then sample at the
  // falling edge.
  task automatic tick();
    bit acc8 = v8 && (q8.size() <= 1);
    bit acc4 = v4 && (q4.size() <= 1);
    @(posedge clk);
    if (!rst) begin
      q8.delete();
      q4.delete();
    end else begin
      if (q8.size() > 0) void'(q8.pop_front());
      if (q4.size() > 0) void'(q4.pop_front());
      if (acc8) for (int i = 7; i >= 0; i--) q8.push_back(d8[i]);
      if (acc4) for (int i = 0; i < 4; i++) q4.push_back(d4[i]);
    end
    @(negedge clk);
    compare_all();
    if (sv8) cap8.push_back(so8);
    if (sv4) cap4.push_back(so4);
    if (fd8) fdc8++;
    if (fd4) fdc4++;
  endtask

  // Offer a word until the model says it is taken; load_valid stays high.
  task automatic send8(input logic [7:0] w);
    bit acc;
    v8 = 1'b1;
    d8 = w;
    for (int n = 0; n < 20; n++) begin
      acc = (q8.size() <= 1);
      tick();
      if (acc) return;
    end
    check("send8_timeout", 32'd0, 32'd1);
  endtask

  task automatic send4(input logic [3:0] w);
    bit acc;
    v4 = 1'b1;
    d4 = w;
    for (int n = 0; n < 20; n++) begin
      acc = (q4.size() <= 1);
      tick();
      if (acc) return;
    end
    check("send4_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_ticks(input int n);
    v8 = 1'b0;
    v4 = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_caps();
    cap8.delete();
    cap4.delete();
    fdc8 = 0;
    fdc4 = 0;
  endtask

  initial begin
    rst = 1'b1;
    v8 = 1'b1; d8 = 8'h3C;
    v4 = 1'b0; d4 = 4'h0;
    #1 rst = 1'b0;

    // Reset held for two edges with load_valid high: nothing is accepted.
    tick();
    tick();
    check("rst_ser_out",    {31'd0, so8},  32'd0);
    check("rst_load_ready", {31'd0, rdy8}, 32'd1);
    check("rst_idle4",      {31'd0, so4},  32'd1);
    rst = 1'b1;
    tick();
    check("rst_first_accept", {31'd0, sv8}, 32'd1);
    idle_ticks(9);
    check("rst_word", pack(cap8), 32'h3C);
    clear_caps();

    // Single word MSB first.
    send8(8'b1110_1101);
    idle_ticks(9);
    check("single_bits",  pack(cap8), 32'hED);
    check("single_len",   cap8.size(), 32'd8);
    check("single_fd",    fdc8, 32'd1);
    check("single_det",   first_111(cap8), 32'd2);
    clear_caps();

    // Back-to-back words: 16 contiguous bits, 111 run across the boundary.
    send8(8'h0F);
    send8(8'hC0);
    idle_ticks(9);
    check("b2b_bits", pack(cap8), 32'h0FC0);
    check("b2b_len",  cap8.size(), 32'd16);
    check("b2b_fd",   fdc8, 32'd2);
    check("b2b_det",  first_111(cap8), 32'd6);
    clear_caps();

    // Mid-frame offer is held off until the last-bit edge.
    send8(8'hA5);
    idle_ticks(2);
    send8(8'hFF);
    idle_ticks(9);
    check("midload_bits", pack(cap8), 32'hA5FF);
    check("midload_len",  cap8.size(), 32'd16);
    clear_caps();

    // Asynchronous reset during bit 4 of 0xFF.
    send8(8'hFF);
    idle_ticks(4);
    #2 rst = 1'b0;
    q8.delete();
    q4.delete();
    #1;
    compare_all();
    check("async_ser_valid", {31'd0, sv8}, 32'd0);
    tick();
    rst = 1'b1;
    clear_caps();
    send8(8'h81);
    idle_ticks(9);
    check("after_rst_bits", pack(cap8), 32'h81);
    check("after_rst_len",  cap8.size(), 32'd8);
    clear_caps();

    // LSB first, WIDTH 4, idle level 1.
    send4(4'b0011);
    idle_ticks(6);
    check("lsb_bits", pack(cap4), 32'b1100);
    check("lsb_fd",   fdc4, 32'd1);
    check("lsb_idle", {31'd0, so4}, 32'd1);
    clear_caps();

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      v8 = ($urandom_range(0, 3) != 0);
      d8 = 8'($urandom);
      v4 = ($urandom_range(0, 2) != 0);
      d4 = 4'($urandom);
      tick();
    end
    idle_ticks(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out bit feeder that sits directly upstream of the 111 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clock on `ser_out`, which drives the detector's serial `in` input. Back-to-back words stream with no idle gap, so bit patterns that span word boundaries reach the detector intact.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is WIDTH ≥ 2.
- `MSB_FIRST`, default 1: bit order. 1 shifts `load_data[WIDTH-1]` first; 0 shifts `load_data[0]` first.
- `IDLE_BIT`, default 0: level driven on `ser_out` whenever no frame bit is being presented.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  upstream has a word on `load_data`.
- `load_data`  in  WIDTH  word to serialize; sampled only on an accepted load.
- `load_ready`  out  1  block can accept a word this cycle.
- `ser_out`  out  1  serial bit; connects to the detector's `in`.
- `ser_valid`  out  1  `ser_out` carries a frame bit this cycle.
- `busy`  out  1  a frame is in progress; equal to `ser_valid`.
- `frame_done`  out  1  one-cycle pulse coinciding with the last bit of each frame.

## Operation
- **States:** IDLE and SHIFT.
  - Internal registers: shift register `sr[WIDTH-1:0]` and bit counter `cnt` of width $clog2(WIDTH).
- **Accept:** a load is accepted on a rising edge where `load_valid && load_ready`.
- **`load_ready` (combinational):**
  - 1 in IDLE.
  - 1 in SHIFT when `cnt == WIDTH-1` (last bit presented).
  - 0 otherwise.
- **IDLE → SHIFT on accept:**
  - `sr` ← `load_data`; `cnt` ← 0.
  - `ser_out` ← first bit, selected by MSB_FIRST.
- **SHIFT, `cnt < WIDTH-1`:**
  - `cnt` increments.
  - `sr` shifts toward the output end.
  - `ser_out` ← next bit.
  - A `load_valid` in this state is ignored: `load_ready` is 0 and the held word is not corrupted.
- **SHIFT, `cnt == WIDTH-1`:**
  - With accept: reload `sr`, set `cnt` to 0, drive the new first bit next cycle, and stay in SHIFT. This gives a gapless stream.
  - Without accept: go to IDLE; `ser_out` ← IDLE_BIT.
- **`frame_done`** = SHIFT && `cnt == WIDTH-1`. It is combinational from registered state and is glitch-free relative to `clk`.
- **Reset (asynchronous):**
  - State goes to IDLE immediately; `cnt` = 0; `sr` = 0.
  - Outputs: `ser_out` = IDLE_BIT, `ser_valid` = 0, `busy` = 0, `frame_done` = 0, `load_ready` = 1.
  - A partially sent frame is discarded with no resume.
  - After `rst` deasserts, the first rising edge with `load_valid` = 1 is accepted.
- **Upstream contract:** `load_data` is don't-care when `load_valid` = 0. No requirement that `load_valid` be held once asserted.

## Timing
- **Latency:** a word accepted at edge N puts bit 0 (first in order) on `ser_out` from edge N to N+1. Bit k is valid from edge N+k to N+k+1.
- **Frame length:** exactly WIDTH cycles with `ser_valid` = 1.
- **`frame_done`:** high during the cycle of bit WIDTH-1.
- **Back-to-back:** accepting at the last-bit edge places the next word's bit 0 in the immediately following cycle. `ser_valid` stays continuously 1.
- **Throughput:** one bit per clock; one word per WIDTH clocks at most.
- **Output registering:** `ser_out`, `ser_valid` and `busy` are registered. They change only on rising edges or on asynchronous reset.
- **Detector handoff:** the detector samples `ser_out` on the next rising edge after it is driven.

## Test plan
1. **Reset values.** Hold `rst` = 0 for 2 cycles with `load_valid` = 1, then release.
   - During reset: `ser_out` = 0, `ser_valid` = 0, `load_ready` = 1, `frame_done` = 0.
   - The first edge after release accepts the word.
2. **Single word, MSB first.** Load 8'b1110_1101, then drop `load_valid`.
   - `ser_out` over 8 cycles: 1,1,1,0,1,1,0,1.
   - `frame_done` high only in cycle 8.
   - Then `ser_out` = 0 and `ser_valid` = 0.
   - Downstream detector fires on the third 1.
3. **Back-to-back.** Hold `load_valid` = 1 with words 8'h0F then 8'hC0.
   - 16 contiguous valid bits: 00001111 11000000.
   - No gap cycle; `frame_done` pulses at cycles 8 and 16.
   - The cross-boundary 111 run reaches the detector intact.
4. **Mid-frame load ignored.** Start 8'hA5; at cycle 3 assert `load_valid` with 8'hFF until `load_ready`.
   - 8'hA5 completes unchanged: 1,0,1,0,0,1,0,1.
   - 8'hFF is accepted at the last-bit edge and follows gaplessly.
5. **Reset mid-frame.** Assert `rst` asynchronously at bit 4 of 8'hFF.
   - Outputs go to idle before the next edge.
   - After release, load 8'h81: exactly 1,0,0,0,0,0,0,1, with no stale bits.
6. **LSB first.** MSB_FIRST = 0, IDLE_BIT = 1, WIDTH = 4; load 4'b0011.
   - `ser_out` sequence: 1,1,0,0.
   - `ser_out` = 1 while idle.
